// File: rtl/y86_pkg.sv
// Y86-64 shared pipeline definitions: status codes, special register/instruction
// ids and the stage record layout carried between pipeline stages.
package y86_pkg;

  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  localparam logic [3:0] ICODE_NOP       = 4'h1;
  localparam logic [3:0] REG_NONE        = 4'hF;
  localparam int         HDR_W           = 11;
  localparam int         STAGE_PAYLOAD_W = 256;

  typedef struct packed {
    stat_t      stat;
    logic [3:0] icode;
    logic [3:0] ifun;
  } stage_hdr_t;

  // Full-width record for callers using the default payload width.
  typedef struct packed {
    stat_t                      stat;
    logic [3:0]                 icode;
    logic [3:0]                 ifun;
    logic [STAGE_PAYLOAD_W-1:0] payload;
  } stage_rec_t;

  localparam stage_hdr_t BUBBLE_HDR = '{stat: SBUB, icode: ICODE_NOP, ifun: 4'h0};

endpackage

// File: rtl/y86_skid_slot.sv
// One record register plus valid flag. load wins over clr; clr only drops the
// valid flag so the last record stays visible on the data lines.
module y86_skid_slot #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else if (load) begin
      data_q <= d;
      vld_q  <= 1'b1;
    end else if (clr) begin
      vld_q  <= 1'b0;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;

endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Generic Y86-64 stage-boundary register: bubble/stall hazard control, valid/ready
// handshake with a 2-entry skid (main M + skid S) and a saturating bubble counter.
module y86_pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int                   PAYLOAD_W      = 256,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = {PAYLOAD_W{1'b1}},
  parameter int                   CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_stat,
  input  logic [3:0]           in_icode,
  input  logic [3:0]           in_ifun,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_stat,
  output logic [3:0]           out_icode,
  output logic [3:0]           out_ifun,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int               REC_W   = HDR_W + PAYLOAD_W;
  localparam logic [REC_W-1:0] BUB_REC = {BUBBLE_HDR, BUBBLE_PAYLOAD};

  logic [REC_W-1:0] in_rec, m_q, s_q, m_d;
  logic             m_vld, s_vld;
  logic             m_load, m_clr, s_load, s_clr;
  logic             acc, take;
  logic [CNT_W-1:0] bubble_cnt_q;

  assign in_rec   = {in_stat, in_icode, in_ifun, in_payload};
  assign in_ready = !s_vld && !stall;
  assign acc      = in_valid && in_ready;
  assign take     = m_vld && out_ready;

  always_comb begin
    m_load = 1'b0;
    m_clr  = 1'b0;
    s_load = 1'b0;
    s_clr  = 1'b0;
    m_d    = in_rec;
    if (bubble) begin
      // Squash: both slots lose their beats, incoming beat is dropped.
      m_load = 1'b1;
      m_d    = BUB_REC;
      s_clr  = 1'b1;
    end else if (stall) begin
      // hold everything
    end else if (!m_vld || take) begin
      if (s_vld) begin
        m_load = 1'b1;
        m_d    = s_q;
        s_load = acc;
        s_clr  = !acc;
      end else if (acc) begin
        m_load = 1'b1;
      end else begin
        m_clr  = 1'b1;
      end
    end else begin
      s_load = acc;
    end
  end

  y86_skid_slot #(.W(REC_W), .RST_VAL(BUB_REC)) u_m (
    .clk (clk), .rst_n (rst_n), .load (m_load), .clr (m_clr),
    .d   (m_d), .q     (m_q),   .vld  (m_vld)
  );

  y86_skid_slot #(.W(REC_W), .RST_VAL(BUB_REC)) u_s (
    .clk (clk),    .rst_n (rst_n), .load (s_load), .clr (s_clr),
    .d   (in_rec), .q     (s_q),   .vld  (s_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         bubble_cnt_q <= '0;
    else if (bubble && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
  end

  assign {out_stat, out_icode, out_ifun, out_payload} = m_q;
  assign out_valid  = m_vld;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// Directed bench for y86_pipe_stage_reg (16-bit payload, 2-bit bubble counter).
module tb_y86_pipe_stage_reg;

  localparam int PW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n, stall, bubble, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    in_stat, out_stat;
  logic [3:0]    in_icode, in_ifun, out_icode, out_ifun;
  logic [PW-1:0] in_payload, out_payload;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  y86_pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk (clk), .rst_n (rst_n), .stall (stall), .bubble (bubble),
    .in_valid (in_valid), .in_ready (in_ready), .in_stat (in_stat),
    .in_icode (in_icode), .in_ifun (in_ifun), .in_payload (in_payload),
    .out_valid (out_valid), .out_ready (out_ready), .out_stat (out_stat),
    .out_icode (out_icode), .out_ifun (out_ifun), .out_payload (out_payload),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [3:0] ic);
    in_valid   = v;
    in_stat    = 3'd1;
    in_icode   = ic;
    in_ifun    = ic ^ 4'h5;
    in_payload = 16'hC000 | 16'(ic);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ic);
    chk({tag, ".v"}, int'(out_valid), 1);
    chk({tag, ".icode"}, int'(out_icode), int'(ic));
    chk({tag, ".ifun"}, int'(out_ifun), int'(ic ^ 4'h5));
    chk({tag, ".stat"}, int'(out_stat), 1);
    chk({tag, ".pay"}, int'(out_payload), int'(16'hC000 | 16'(ic)));
  endtask

  task automatic chk_bub(input string tag);
    chk({tag, ".icode"}, int'(out_icode), 1);
    chk({tag, ".stat"}, int'(out_stat), 0);
    chk({tag, ".ifun"}, int'(out_ifun), 0);
    chk({tag, ".pay"}, int'(out_payload), 'hFFFF);
  endtask

  initial begin
    // 1. reset with random inputs
    rst_n = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stall = 1'($urandom); bubble = 1'($urandom);
      beat(1'($urandom), 4'($urandom));
      tick();
      chk("rst.v", int'(out_valid), 0);
      chk_bub("rst");
      chk("rst.cnt", int'(bubble_cnt), 0);
    end
    stall = 1'b0; bubble = 1'b0; beat(1'b0, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("idle.v", int'(out_valid), 0);

    // 2. streaming
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 4'(i));
      #1 chk("str.rdy", int'(in_ready), 1);
      tick();
      chk_out("str", 4'(i));
    end
    beat(1'b0, 4'h0);
    tick();
    chk("str.drain", int'(out_valid), 0);

    // 3. back-pressure: 3 cycles with out_ready=0
    beat(1'b1, 4'h1); tick(); chk_out("bp.m1", 4'h1);
    out_ready = 1'b0;
    beat(1'b1, 4'h2);
    #1 chk("bp.rdy0", int'(in_ready), 1);
    tick(); chk_out("bp.hold1", 4'h1);
    beat(1'b1, 4'h3);
    #1 chk("bp.full", int'(in_ready), 0);
    tick(); chk_out("bp.hold2", 4'h1);
    tick(); chk_out("bp.hold3", 4'h1);
    chk("bp.full2", int'(in_ready), 0);
    out_ready = 1'b1;
    tick(); chk_out("bp.s2", 4'h2);
    chk("bp.rdy1", int'(in_ready), 1);
    tick(); chk_out("bp.b3", 4'h3);
    beat(1'b0, 4'h0);
    tick(); chk("bp.drain", int'(out_valid), 0);

    // 4. stall with icode 6 resident
    beat(1'b1, 4'h6); tick(); chk_out("st.m6", 4'h6);
    stall = 1'b1; beat(1'b1, 4'h7);
    #1 chk("st.rdy", int'(in_ready), 0);
    tick(); chk_out("st.h1", 4'h6);
    tick(); chk_out("st.h2", 4'h6);
    chk("st.cnt", int'(bubble_cnt), 0);
    stall = 1'b0;
    #1 chk_out("st.rel", 4'h6);
    chk("st.rdy1", int'(in_ready), 1);
    tick(); chk_out("st.b7", 4'h7);
    beat(1'b0, 4'h0);
    tick(); chk("st.drain", int'(out_valid), 0);

    // 5. bubble beats stall, incoming icode 2 squashed
    bubble = 1'b1; stall = 1'b1; beat(1'b1, 4'h2);
    tick();
    chk("bb.v", int'(out_valid), 1);
    chk_bub("bb");
    chk("bb.cnt", int'(bubble_cnt), 1);
    bubble = 1'b0; stall = 1'b0; beat(1'b0, 4'h0);
    tick(); chk("bb.gone", int'(out_valid), 0);

    // bubble with skid full clears the skid
    out_ready = 1'b0;
    beat(1'b1, 4'h8); tick();
    beat(1'b1, 4'h9); tick(); chk_out("sq.m8", 4'h8);
    bubble = 1'b1; beat(1'b0, 4'h0); tick();
    chk_bub("sq");
    chk("sq.cnt", int'(bubble_cnt), 2);
    chk("sq.rdy", int'(in_ready), 1);
    bubble = 1'b0; out_ready = 1'b1;
    tick(); chk("sq.empty", int'(out_valid), 0);

    // 6. saturation: three more bubbles -> 5 total
    bubble = 1'b1;
    tick(); chk("sat.3", int'(bubble_cnt), 3);
    tick(); chk("sat.4", int'(bubble_cnt), 3);
    tick(); chk("sat.5", int'(bubble_cnt), 3);
    bubble = 1'b0;

    // async reset mid-stream, checked before the next edge
    beat(1'b1, 4'h5); tick(); chk_out("ar.m5", 4'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.v", int'(out_valid), 0);
    chk_bub("ar");
    chk("ar.cnt", int'(bubble_cnt), 0);
    beat(1'b0, 4'h0); rst_n = 1'b1;
    tick(); chk("ar.post", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
